seq_div_8bit: RTL

Multi-cycle unsigned 8-bit restoring divider. It is the inverse-direction companion to the team's 8-bit carry-lookahead adder: it performs one shift-and-subtract step per clock through a CLA-style subtractor. It sits beside the ALU as a start/done coprocessor. The ALU issues an operand pair and later collects the quotient, remainder and divide-by-zero flag.

---
 rtl/div_pkg.sv | 15 +
 rtl/cla_sub.sv | 40 ++++
 rtl/seq_div_8bit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// DIV_SIGNED_EN makes the FIX state reachable; its encoding is always reserved.
package div_pkg;

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/cla_sub.sv
// Combinational a - b computed as a + ~b + 1 using 4-bit carry-lookahead groups.
// Group carries ripple between groups; borrow is the inverted final carry-out.
module cla_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each bit's carry is expanded from its group's carry-in, not from the previous bit.
  always_comb begin
    logic [NG:0] gc;
    logic        acc;
    gc    = '0;
    gc[0] = 1'b1;
    acc   = 1'b0;
    diff  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      acc = gc[k/4];
      for (int j = (k/4)*4; j < k; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      diff[k] = p[k] ^ acc;
      if ((k % 4 == 3) || (k == WIDTH - 1)) begin
        gc[k/4 + 1] = g[k] | (p[k] & acc);
      end
    end
    borrow = ~gc[NG];
  end

endmodule

// File: rtl/seq_div_8bit.sv
// Restoring divider, one quotient bit per clock: done WIDTH cycles after start, 1 cycle for /0.
// No backpressure: start only taken in IDLE; DIV_SIGNED_EN adds signed operands and a FIX cycle.
module seq_div_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state, state_nxt;
  logic             done_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd, dvs, q_sh, q_nxt;
  logic [WIDTH:0]   rem_p, shifted, sub_diff, rem_nxt;
  logic             sub_borrow;
  logic             zero_pend;
  logic             unused_rem_msb;
`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign shifted = {rem_p[WIDTH-1:0], dvd[WIDTH-1]};

  cla_sub #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  assign rem_nxt = sub_borrow ? shifted : sub_diff;
  assign q_nxt   = {q_sh[WIDTH-2:0], ~sub_borrow};
  assign busy    = (state == ST_RUN) || (state == ST_FIX);
  // A restored remainder is always below the divisor, so its top bit is never fed back.
  assign unused_rem_msb = rem_p[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = (divisor == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (count == CW'(1)) begin
`ifdef DIV_SIGNED_EN
          state_nxt = ST_FIX;
`else
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      ST_FIX: begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
      end
`endif
      // Divide-by-zero spends a first DONE cycle posting its results.
      ST_DONE: begin
        if (zero_pend) done_nxt = 1'b1;
        else           state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q_sh        <= '0;
      rem_p       <= '0;
      zero_pend   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= done_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_p <= '0;
            q_sh  <= '0;
            count <= CW'(WIDTH);
            if (divisor == '0) begin
              dvd       <= dividend;
              dvs       <= divisor;
              zero_pend <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              dvd   <= dividend[WIDTH-1] ? -dividend : dividend;
              dvs   <= divisor[WIDTH-1] ? -divisor : divisor;
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
`else
              dvd   <= dividend;
              dvs   <= divisor;
`endif
            end
          end
        end
        ST_RUN: begin
          dvd   <= dvd << 1;
          rem_p <= rem_nxt;
          q_sh  <= q_nxt;
          count <= count - CW'(1);
`ifndef DIV_SIGNED_EN
          if (count == CW'(1)) begin
            quotient  <= q_nxt;
            remainder <= rem_nxt[WIDTH-1:0];
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        ST_FIX: begin
          quotient  <= neg_q ? -q_sh : q_sh;
          remainder <= neg_r ? -rem_p[WIDTH-1:0] : rem_p[WIDTH-1:0];
        end
`endif
        ST_DONE: begin
          if (zero_pend) begin
            quotient    <= DBZ_QUOT;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
            zero_pend   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
